// File: rtl/axis_avg_pkg.sv
// Shared types and constants for the BRAM averager read-out path.
package axis_avg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int SKID_DEPTH      = 2;

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry register FIFO carrying {tlast, tdata} with an AXI4-Stream read side.
module axis_skid_buf2 #(
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          full,
    output logic          almost_full,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast
);
    import axis_avg_pkg::*;

    logic [DW:0] mem [SKID_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  cnt;
    logic        pop;

    assign pop         = m_tvalid & m_tready;
    assign full        = (cnt == 2'(SKID_DEPTH));
    assign almost_full = (cnt == 2'(SKID_DEPTH - 1));
    assign m_tvalid    = (cnt != 2'd0);
    assign {m_tlast, m_tdata} = mem[rd_ptr];

    // The head entry is only replaced by advancing rd_ptr, so the
    // presented beat holds steady while the consumer stalls.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {wr_last, wr_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(wr_en) - 2'(pop);
        end
    end

endmodule

// File: rtl/axis_bram_avg_reader.sv
// Streams accumulated sums from BRAM port B onto an AXI4-Stream master.
// Optional AVG_SHIFT_EN adds avg_shift: arithmetic right shift of each word.
module axis_bram_avg_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic [15:0]                 nsamples,
`ifdef AVG_SHIFT_EN
    input  logic [4:0]                  avg_shift,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        bram_portb_clk,
    output logic                        bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0]  bram_portb_wrdata,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
    output logic                        bram_portb_we,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);
    import axis_avg_pkg::*;

    state_t state, state_next;

    logic                       start_d;
    logic                       start_edge;
    logic [15:0]                nlat;
    logic [15:0]                rd_cnt;
    logic [15:0]                out_cnt;
    logic [BRAM_RD_LATENCY-1:0] rd_vld;
    logic [BRAM_RD_LATENCY-1:0] rd_last;
    logic                       load;
    logic                       issue;
    logic                       done_next;
    logic                       pop;
    logic                       room;
    logic [1:0]                 occ;
    logic                       skid_full;
    logic                       skid_afull;
    logic [BRAM_DATA_WIDTH-1:0] wr_data;
    logic [BRAM_DATA_WIDTH-1:0] skid_tdata;
    logic                       rd_is_last;
    logic                       out_is_last;

    assign bram_portb_clk    = aclk;
    assign bram_portb_rst    = ~aresetn;
    assign bram_portb_wrdata = '0;
    assign bram_portb_we     = 1'b0;

    assign start_edge  = start & ~start_d;
    assign busy        = (state != IDLE);
    assign pop         = m_axis_tvalid & m_axis_tready;
    assign rd_is_last  = (rd_cnt == nlat - 16'd1);
    assign out_is_last = (out_cnt == nlat - 16'd1);

    // Slots committed after this cycle's pop; a new read may only go
    // out if its data is guaranteed a free skid entry.
    assign occ  = {skid_full, skid_afull} - {1'b0, pop}
                + {1'b0, rd_vld[BRAM_RD_LATENCY-1]};
    assign room = (occ < 2'(SKID_DEPTH));

`ifdef AVG_SHIFT_EN
    logic [4:0] shift_lat;
    assign wr_data = $signed(bram_portb_rddata) >>> shift_lat;
`else
    assign wr_data = bram_portb_rddata;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    if (nsamples == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_is_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_is_last) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            start_d         <= 1'b0;
            done            <= 1'b0;
            nlat            <= '0;
            rd_cnt          <= '0;
            out_cnt         <= '0;
            rd_vld          <= '0;
            rd_last         <= '0;
            bram_portb_addr <= '0;
`ifdef AVG_SHIFT_EN
            shift_lat       <= '0;
`endif
        end else begin
            start_d <= start;
            done    <= done_next;
            rd_vld  <= BRAM_RD_LATENCY'(issue);
            rd_last <= BRAM_RD_LATENCY'(issue & rd_is_last);
            if (load) begin
                nlat    <= nsamples;
                rd_cnt  <= '0;
                out_cnt <= '0;
`ifdef AVG_SHIFT_EN
                shift_lat <= avg_shift;
`endif
            end else begin
                if (issue) begin
                    rd_cnt <= rd_cnt + 16'd1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 16'd1;
                end
            end
            if (issue) begin
                bram_portb_addr <= BRAM_ADDR_WIDTH'(rd_cnt);
            end else if (state_next == IDLE) begin
                bram_portb_addr <= '0;
            end
        end
    end

    axis_skid_buf2 #(
        .DW(BRAM_DATA_WIDTH)
    ) u_skid (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .wr_en       (rd_vld[BRAM_RD_LATENCY-1]),
        .wr_data     (wr_data),
        .wr_last     (rd_last[BRAM_RD_LATENCY-1]),
        .full        (skid_full),
        .almost_full (skid_afull),
        .m_tdata     (skid_tdata),
        .m_tvalid    (m_axis_tvalid),
        .m_tready    (m_axis_tready),
        .m_tlast     (m_axis_tlast)
    );

    assign m_axis_tdata = AXIS_TDATA_WIDTH'(skid_tdata);

endmodule
